// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (a - b - bin), one borrow-lookahead nibble per clock,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_borrow;
    logic             r_startReady;
    logic             r_doneValid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_overflow;
    logic             r_zero;

    logic [3:0]       w_aNib;
    logic [3:0]       w_bNib;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [3:0]       w_c;
    logic [3:0]       w_dNib;
    logic [WIDTH-1:0] w_diffNext;
    logic             w_lastNib;

    always_comb begin
        w_aNib = '0;
        w_bNib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (r_idx == IW'(k)) begin
                w_aNib = r_a[4*k +: 4];
                w_bNib = r_b[4*k +: 4];
            end
        end
    end

    // Borrow-lookahead slice; r_borrow holds the latched bin for nibble 0
    // and the previous nibble's borrow-out afterwards.
    assign w_g = ~w_aNib & w_bNib;
    assign w_p = ~(w_aNib ^ w_bNib);

    assign w_c[0] = w_g[0] | (w_p[0] & r_borrow);
    assign w_c[1] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
    assign w_c[2] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
    assign w_c[3] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);

    assign w_dNib    = w_aNib ^ w_bNib ^ {w_c[2:0], r_borrow};
    assign w_lastNib = (r_idx == IW'(NIB - 1));

    always_comb begin
        w_diffNext = r_diff;
        for (int k = 0; k < NIB; k++) begin
            if (r_idx == IW'(k)) begin
                w_diffNext[4*k +: 4] = w_dNib;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_idx        <= '0;
            r_borrow     <= 1'b0;
            r_startReady <= 1'b1;
            r_doneValid  <= 1'b0;
            r_diff       <= '0;
            r_bout       <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_a          <= a;
                        r_b          <= b;
                        r_borrow     <= bin;
                        r_idx        <= '0;
                        r_startReady <= 1'b0;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    r_diff   <= w_diffNext;
                    r_borrow <= w_c[3];
                    r_idx    <= r_idx + IW'(1);
                    if (w_lastNib) begin
                        r_bout      <= w_c[3];
                        r_overflow  <= (r_a[WIDTH-1] != r_b[WIDTH-1])
                                     & (w_diffNext[WIDTH-1] != r_a[WIDTH-1]);
                        r_zero      <= ~|w_diffNext;
                        r_doneValid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        r_doneValid  <= 1'b0;
                        r_startReady <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_doneValid  <= 1'b0;
                    r_startReady <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = r_startReady;
    assign done_valid  = r_doneValid;
    assign diff        = r_diff;
    assign bout        = r_bout;
    assign overflow    = r_overflow;
    assign zero        = r_zero;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_nibble_serial_subtractor;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk;
   logic             rst_n;
   logic             startValid;
   logic             startReady;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             opBin;
   logic             doneValid;
   logic             doneReady;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             overflow;
   logic             zero;

   int nCompared;
   int nMismatched;

   nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (startValid),
      .start_ready (startReady),
      .a           (opA),
      .b           (opB),
      .bin         (opBin),
      .done_valid  (doneValid),
      .done_ready  (doneReady),
      .diff        (diff),
      .bout        (bout),
      .overflow    (overflow),
      .zero        (zero)
   );

   // 10 ns clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference model: plain wide arithmetic, unsigned for borrow and signed range for overflow
   task automatic modelSub(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin,
                           output logic [WIDTH-1:0] eDiff, output logic eBout,
                           output logic eOvf, output logic eZero);
      int unsigned ua;
      int unsigned ub;
      int sa;
      int sb;
      int sr;
      ua = ta;
      ub = tb;
      sa = int'($signed(ta));
      sb = int'($signed(tb));
      sr = sa - sb - int'(tbin);
      eDiff = WIDTH'((ua + 32'h10000 - ub - tbin) & 32'hFFFF);
      eBout = (ua < ub + tbin);
      eOvf  = (sr > 32767) || (sr < -32768);
      eZero = (eDiff == '0);
   endtask

   // Runs one operation from IDLE: optional operand scrambling during RUN and
   // optional extra cycles in DONE with done_ready low before handing the result off
   task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin,
                                input bit scramble, input int holdCycles);
      logic [WIDTH-1:0] eDiff;
      logic             eBout;
      logic             eOvf;
      logic             eZero;
      int               lat;
      modelSub(ta, tb, tbin, eDiff, eBout, eOvf, eZero);
      @(negedge clk);
      checkOutput("start_ready_idle", startReady, 1);
      opA        = ta;
      opB        = tb;
      opBin      = tbin;
      startValid = 1'b1;
      doneReady  = 1'b0;
      @(posedge clk);
      #1;
      startValid = 1'b0;
      lat = 0;
      while (!doneValid && lat < 20) begin
         checkOutput("start_ready_run", startReady, 0);
         if (scramble) begin
            opA   = WIDTH'($urandom);
            opB   = WIDTH'($urandom);
            opBin = 1'($urandom);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("latency", lat, NIB);
      for (int h = 0; h <= holdCycles; h++) begin
         @(negedge clk);
         checkOutput("done_valid", doneValid, 1);
         checkOutput("start_ready_done", startReady, 0);
         checkOutput("diff", diff, eDiff);
         checkOutput("bout", bout, eBout);
         checkOutput("overflow", overflow, eOvf);
         checkOutput("zero", zero, eZero);
      end
      doneReady = 1'b1;
      @(posedge clk);
      #1;
      doneReady = 1'b0;
      checkOutput("done_valid_cleared", doneValid, 0);
      checkOutput("start_ready_back", startReady, 1);
      checkOutput("diff_kept", diff, eDiff);
   endtask

   initial begin
      logic [WIDTH-1:0] eDiff;
      logic             eBout;
      logic             eOvf;
      logic             eZero;
      int               lastAccept;
      int               nAccepts;

      nCompared   = 0;
      nMismatched = 0;
      rst_n       = 1'b0;
      startValid  = 1'b0;
      doneReady   = 1'b0;
      opA         = '0;
      opB         = '0;
      opBin       = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("rst_start_ready", startReady, 1);
      checkOutput("rst_done_valid", doneValid, 0);
      checkOutput("rst_diff", diff, 0);
      checkOutput("rst_flags", {bout, overflow, zero}, 0);
      rst_n = 1'b1;

      applyStimulus(16'h1234, 16'h0235, 1'b0, 1'b0, 0);
      applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b0, 0);
      applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
      applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b0, 0);
      applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 0);
      applyStimulus(16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 5);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0);

      // Back-to-back with done_ready tied high: accepts must be NIB+2 cycles apart
      modelSub(16'h4321, 16'h1234, 1'b1, eDiff, eBout, eOvf, eZero);
      @(negedge clk);
      opA        = 16'h4321;
      opB        = 16'h1234;
      opBin      = 1'b1;
      startValid = 1'b1;
      doneReady  = 1'b1;
      lastAccept = -1;
      nAccepts   = 0;
      for (int cyc = 0; cyc < 3 * (NIB + 2) + 1; cyc++) begin
         if (startReady) begin
            if (lastAccept >= 0) checkOutput("accept_spacing", cyc - lastAccept, NIB + 2);
            lastAccept = cyc;
            nAccepts++;
         end
         if (doneValid) checkOutput("b2b_diff", diff, eDiff);
         checkOutput("ready_valid_exclusive", startReady & doneValid, 0);
         @(negedge clk);
      end
      checkOutput("b2b_accepts", nAccepts, 4);
      startValid = 1'b0;
      while (!startReady) begin
         doneReady = 1'b1;
         @(negedge clk);
      end
      doneReady = 1'b0;

      // Abort mid-RUN after two nibbles, then verify a clean follow-up op
      @(negedge clk);
      opA        = 16'hFFFF;
      opB        = 16'h1111;
      opBin      = 1'b1;
      startValid = 1'b1;
      @(posedge clk);
      #1;
      startValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_start_ready", startReady, 1);
      checkOutput("abort_done_valid", doneValid, 0);
      checkOutput("abort_diff", diff, 0);
      checkOutput("abort_flags", {bout, overflow, zero}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(16'h0010, 16'h0001, 1'b0, 1'b0, 0);

      for (int n = 0; n < 30; n++) begin
         applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                       1'($urandom), int'($urandom_range(0, 2)));
      end
      applyStimulus(16'h0001, 16'h0000, 1'b1, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
